// File: rtl/dkong_i2s_tx.sv
// Philips I2S stereo transmitter for the mono 16-bit sound mixer output, with a 1-deep pending buffer.
// Optional macro DKONG_I2S_VOLUME_EN enables arithmetic-shift attenuation by I_VOL at frame load.
module dkong_i2s_tx #(
  parameter int unsigned BCLK_DIV  = 8,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        W_CLK_24576M,
  input  logic        W_RESET,
  input  logic [15:0] I_SAMPLE,
  input  logic        I_SAMPLE_EN,
  input  logic        I_FLAG_CLR,
  input  logic [2:0]  I_VOL,
  output logic        O_MCLK,
  output logic        O_BCLK,
  output logic        O_LRCLK,
  output logic        O_SDATA,
  output logic        O_FRAME,
  output logic        O_OVERRUN,
  output logic        O_UNDERRUN
);

  localparam int unsigned NBITS = 2 * SLOT_BITS;
  localparam int unsigned PW    = $clog2(BCLK_DIV);
  localparam int unsigned BW    = $clog2(NBITS);

  typedef enum logic {
    PEND_STALE = 1'b0,
    PEND_FRESH = 1'b1
  } pend_e;

  logic [PW-1:0] p_q, p_d;
  logic [BW-1:0] b_q, b_d;
  pend_e         pstate_q, pstate_d;
  logic [15:0]   pend_q, pend_d;
  logic [15:0]   last_q, last_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          mclk_q, mclk_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          frame_q, frame_d;
  logic          ovr_q, ovr_d;
  logic          und_q, und_d;

  logic          load;
  logic          ovr_set, und_set;
  logic [15:0]   src;
  logic [BW-1:0] slot_bit, slot_pos;

`ifndef DKONG_I2S_VOLUME_EN
  logic unused_vol;
  assign unused_vol = ^I_VOL;
`endif

  always_ff @(posedge W_CLK_24576M) begin
    if (W_RESET) begin
      p_q      <= '0;
      b_q      <= '0;
      pstate_q <= PEND_STALE;
      pend_q   <= '0;
      last_q   <= '0;
      shreg_q  <= '0;
      mclk_q   <= 1'b0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      frame_q  <= 1'b0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      p_q      <= p_d;
      b_q      <= b_d;
      pstate_q <= pstate_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      mclk_q   <= mclk_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      frame_q  <= frame_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  always_comb begin
    p_d      = p_q;
    b_d      = b_q;
    pstate_d = pstate_q;
    pend_d   = pend_q;
    last_d   = last_q;
    shreg_d  = shreg_q;
    src      = last_q;
    ovr_set  = 1'b0;
    und_set  = 1'b0;

    // The frame counter is kept as (bit, phase) pairs so no divider is needed for odd-ish BCLK_DIV.
    load = (b_q == BW'(NBITS - 1)) && (p_q == PW'(BCLK_DIV - 1));
    if (p_q == PW'(BCLK_DIV - 1)) begin
      p_d = '0;
      b_d = (b_q == BW'(NBITS - 1)) ? '0 : b_q + 1'b1;
    end else begin
      p_d = p_q + 1'b1;
    end

    if (load) begin
      if (pstate_q == PEND_FRESH) begin
        src      = pend_q;
        pstate_d = PEND_STALE;
      end else if (I_SAMPLE_EN) begin
        src = I_SAMPLE;
      end else begin
        und_set = 1'b1;
      end
      last_d = src;
`ifdef DKONG_I2S_VOLUME_EN
      shreg_d = $signed(src) >>> I_VOL;
`else
      shreg_d = src;
`endif
    end

    // A strobe on a stale load cycle is consumed by the bypass and never reaches the pending slot.
    if (I_SAMPLE_EN && !(load && pstate_q == PEND_STALE)) begin
      pend_d   = I_SAMPLE;
      pstate_d = PEND_FRESH;
      if (pstate_q == PEND_FRESH && !load) ovr_set = 1'b1;
    end

    ovr_d = ovr_set | (ovr_q & ~I_FLAG_CLR);
    und_d = und_set | (und_q & ~I_FLAG_CLR);

    mclk_d  = ~mclk_q;
    bclk_d  = (p_q >= PW'(BCLK_DIV / 2));
    lrclk_d = (b_q >= BW'(SLOT_BITS));
    frame_d = load;

    // Philips delay: bit b carries slot bit b-1, wrapping b=0 onto the last right-slot bit.
    slot_bit = (b_q == '0) ? BW'(NBITS - 1) : b_q - 1'b1;
    slot_pos = (slot_bit >= BW'(SLOT_BITS)) ? slot_bit - BW'(SLOT_BITS) : slot_bit;
    sdata_d  = 1'b0;
    if (slot_pos < BW'(16)) sdata_d = shreg_q[4'(BW'(15) - slot_pos)];
  end

  assign O_MCLK     = mclk_q;
  assign O_BCLK     = bclk_q;
  assign O_LRCLK    = lrclk_q;
  assign O_SDATA    = sdata_q;
  assign O_FRAME    = frame_q;
  assign O_OVERRUN  = ovr_q;
  assign O_UNDERRUN = und_q;

endmodule

// File: tb/tb_dkong_i2s_tx.sv
// Self-checking bench for dkong_i2s_tx: expected frame words queued at strobe time, compared per captured frame.
module tb_dkong_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_en = 1'b0;
  logic        flag_clr = 1'b0;
  logic [2:0]  vol = '0;
  logic        mclk, bclk, lrclk, sdata, frame, ovr, und;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  dkong_i2s_tx #(.BCLK_DIV(8), .SLOT_BITS(32)) dut (
    .W_CLK_24576M(clk),
    .W_RESET     (rst),
    .I_SAMPLE    (sample),
    .I_SAMPLE_EN (sample_en),
    .I_FLAG_CLR  (flag_clr),
    .I_VOL       (vol),
    .O_MCLK      (mclk),
    .O_BCLK      (bclk),
    .O_LRCLK     (lrclk),
    .O_SDATA     (sdata),
    .O_FRAME     (frame),
    .O_OVERRUN   (ovr),
    .O_UNDERRUN  (und)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] v);
    sample    = v;
    sample_en = 1'b1;
    step(1);
    sample_en = 1'b0;
  endtask

  task automatic clr_pulse();
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
  endtask

  // Leaves the bench on the negedge where O_FRAME is high (counter at 0).
  task automatic sync_frame();
    for (int i = 0; i < 600 && frame !== 1'b1; i++) step(1);
    if (frame !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_sync: O_FRAME=%b, required 1 within 600 clk", frame);
    end
  endtask

  // Captures one frame mid-bit and compares it with the next queued word; ends at counter 509.
  task automatic frame_check(input string name);
    logic [63:0] cap;
    logic [63:0] expv;
    logic [15:0] w;
    sync_frame();
    for (int b = 0; b < 64; b++) begin
      step(b == 0 ? 5 : 8);
      cap[63-b] = sdata;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: frame %h captured with no expected word queued", name, cap);
    end else begin
      w    = exp_q.pop_front();
      expv = {1'b0, w, 16'h0000, w, 15'h0000};
      if (cap !== expv) begin
        n_err++;
        $display("FAIL %s: frame %h, required %h (word %h)", name, cap, expv, w);
      end
    end
  endtask

  task automatic test_reset();
    step(3);
    n_vec++;
    if ({mclk, bclk, lrclk, sdata, frame, ovr, und} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: %b, required 0000000", {mclk, bclk, lrclk, sdata, frame, ovr, und});
    end
    rst = 1'b0;
  endtask

  task automatic test_clocks();
    int last_m = -1, last_b = -1, last_l = -1;
    int per_m = 0, per_b = 0, per_l = 0;
    logic pm = 1'b0, pb = 1'b0, pl = 1'b0;
    logic sd_or = 1'b0;
    logic und_before = 1'bx, und_at = 1'bx;
    for (int t = 1; t <= 1100; t++) begin
      step(1);
      if (mclk && !pm) begin if (last_m >= 0) per_m = t - last_m; last_m = t; end
      if (bclk && !pb) begin if (last_b >= 0) per_b = t - last_b; last_b = t; end
      if (lrclk && !pl) begin if (last_l >= 0) per_l = t - last_l; last_l = t; end
      pm = mclk; pb = bclk; pl = lrclk;
      sd_or |= sdata;
      if (t == 511) und_before = und;
      if (t == 512) und_at = und;
    end
    n_vec++; if (per_m !== 2)   begin n_err++; $display("FAIL mclk_period: %0d, required 2", per_m); end
    n_vec++; if (per_b !== 8)   begin n_err++; $display("FAIL bclk_period: %0d, required 8", per_b); end
    n_vec++; if (per_l !== 512) begin n_err++; $display("FAIL lrclk_period: %0d, required 512", per_l); end
    n_vec++; if (sd_or !== 1'b0) begin n_err++; $display("FAIL first_frames_zero: sdata seen %b, required 0", sd_or); end
    n_vec++; if (und_before !== 1'b0) begin n_err++; $display("FAIL underrun_before_load: %b, required 0", und_before); end
    n_vec++; if (und_at !== 1'b1) begin n_err++; $display("FAIL underrun_first_load: %b, required 1", und_at); end
  endtask

  task automatic test_basic();
    sync_frame();
    clr_pulse();
    step(99);
    strobe(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    frame_check("basic_a5c3");
    n_vec++;
    if ({ovr, und} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_flags: ovr/und %b, required 00", {ovr, und});
    end
  endtask

  task automatic test_overrun();
    sync_frame();
    clr_pulse();
    step(49);
    strobe(16'h1111);
    step(99);
    strobe(16'h2222);
    n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL overrun_set: %b, required 1", ovr); end
    exp_q.push_back(16'h2222);
    frame_check("overrun_newest");
    n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: %b, required 1", ovr); end
    clr_pulse();
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL overrun_clear: %b, required 0", ovr); end
  endtask

  task automatic test_load_collision();
    sync_frame();
    clr_pulse();
    step(199);
    strobe(16'h3C5A);
    exp_q.push_back(16'h3C5A);
    step(310);
    strobe(16'hC0DE);
    exp_q.push_back(16'hC0DE);
    frame_check("collision_old");
    n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL collision_no_overrun: %b, required 0", ovr); end
    frame_check("collision_new");
    n_vec++; if (und !== 1'b0) begin n_err++; $display("FAIL collision_no_underrun: %b, required 0", und); end
  endtask

  task automatic test_clr_priority();
    sync_frame();
    clr_pulse();
    n_vec++; if (und !== 1'b0) begin n_err++; $display("FAIL underrun_clear: %b, required 0", und); end
    step(510);
    flag_clr = 1'b1;
    step(1);
    flag_clr = 1'b0;
    n_vec++; if (und !== 1'b1) begin n_err++; $display("FAIL set_beats_clear: %b, required 1", und); end
    exp_q.push_back(16'hC0DE);
    frame_check("underrun_repeat");
  endtask

  task automatic test_bypass();
    sync_frame();
    clr_pulse();
    step(510);
    strobe(16'h7000);
    exp_q.push_back(16'h7000);
    frame_check("bypass_7000");
    n_vec++;
    if ({ovr, und} !== 2'b00) begin
      n_err++;
      $display("FAIL bypass_flags: ovr/und %b, required 00", {ovr, und});
    end
  endtask

  task automatic test_volume();
    sync_frame();
    vol = 3'd2;
    step(1);
    strobe(16'h8000);
`ifdef DKONG_I2S_VOLUME_EN
    exp_q.push_back(16'hE000);
`else
    exp_q.push_back(16'h8000);
`endif
    frame_check("volume_8000");
    vol = 3'd0;
  endtask

  task automatic test_midframe_reset();
    int lows = 0;
    sync_frame();
    step(300);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_vec++;
    if ({mclk, bclk, lrclk, sdata, frame, ovr, und} !== 7'b0) begin
      n_err++;
      $display("FAIL midframe_reset_outputs: %b, required 0000000", {mclk, bclk, lrclk, sdata, frame, ovr, und});
    end
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (lrclk !== 1'b0) break;
      lows++;
    end
    n_vec++; if (lows !== 256) begin n_err++; $display("FAIL midframe_reset_lrclk_low: %0d clk, required 256", lows); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_clocks();
    test_basic();
    test_overrun();
    test_load_collision();
    test_clr_priority();
    test_bypass();
    test_volume();
    test_midframe_reset();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
